// File: rtl/vrf_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vrf_read_arbiter
// Description : Round-robin sharing of the two combinational VRF read ports
//               among NUM_REQ requesters. One requester is granted per cycle.
//               Its operand addresses drive the VRF directly. The operands
//               read back, with any same-cycle commit write forwarded, are
//               registered and returned one cycle later with the winner's ID.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   arb_hold                   suppresses all grants while high
//   req_valid / req_ready      per-requester request / one-hot grant
//   req_src1 / req_src2        packed operand addresses, requester i at
//                              [i*ADDR_W +: ADDR_W]
//   vrf_read_addr1/2           addresses to the VRF read ports
//   vrf_read_data1/2           combinational VRF read data
//   wb_write_en/addr/data      snoop of the commit write into the VRF
//   rsp_valid/id/data1/data2   registered operand response (1-cycle pulse)
// ============================================================================
module vrf_read_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int VLEN    = 128,
    parameter int ADDR_W  = 5,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arb_hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_src1,
    input  logic [NUM_REQ*ADDR_W-1:0] req_src2,
    output logic [ADDR_W-1:0]         vrf_read_addr1,
    output logic [ADDR_W-1:0]         vrf_read_addr2,
    input  logic [VLEN-1:0]           vrf_read_data1,
    input  logic [VLEN-1:0]           vrf_read_data2,
    input  logic                      wb_write_en,
    input  logic [ADDR_W-1:0]         wb_write_addr,
    input  logic [VLEN-1:0]           wb_write_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [VLEN-1:0]           rsp_data1,
    output logic [VLEN-1:0]           rsp_data2
);

    // One extra bit so rr_ptr + offset never overflows before the modulo fold.
    localparam logic [ID_W:0]   c_NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] c_LAST_ID   = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic               rsp_valid_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [VLEN-1:0]    rsp_data1_q;
    logic [VLEN-1:0]    rsp_data2_q;

    logic               w_grant;
    logic [ID_W-1:0]    w_win_id;
    logic [ID_W:0]      w_scan_idx;
    logic [NUM_REQ-1:0] w_ready;
    logic [ADDR_W-1:0]  w_addr1;
    logic [ADDR_W-1:0]  w_addr2;
    logic [VLEN-1:0]    w_op1;
    logic [VLEN-1:0]    w_op2;

    // Round-robin scan: visit requesters rr_ptr, rr_ptr+1, ... (mod NUM_REQ)
    // and take the first valid one. Reset and hold both block the grant so
    // that nothing is issued or responded to for those cycles.
    always_comb begin : p_scan
        w_grant    = 1'b0;
        w_win_id   = '0;
        w_scan_idx = '0;
        if (!rst && !arb_hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
                if (w_scan_idx >= c_NUM_REQ_W) begin
                    w_scan_idx = w_scan_idx - c_NUM_REQ_W;
                end
                if (!w_grant && req_valid[w_scan_idx[ID_W-1:0]]) begin
                    w_grant  = 1'b1;
                    w_win_id = w_scan_idx[ID_W-1:0];
                end
            end
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority.
    always_comb begin : p_ptr_next
        rr_ptr_d = rr_ptr_q;
        if (w_grant) begin
            rr_ptr_d = (w_win_id == c_LAST_ID) ? '0 : w_win_id + 1'b1;
        end
    end

    // One-hot grant and winner address mux; all zero when nothing is granted.
    always_comb begin : p_grant_mux
        w_ready = '0;
        w_addr1 = '0;
        w_addr2 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant && (w_win_id == ID_W'(k))) begin
                w_ready[k] = 1'b1;
                w_addr1    = req_src1[k*ADDR_W +: ADDR_W];
                w_addr2    = req_src2[k*ADDR_W +: ADDR_W];
            end
        end
    end

    // The VRF returns the pre-write value during a commit cycle, so a
    // matching commit write is forwarded into the operand instead. Each port
    // is compared on its own. Operands are only captured on a grant, so no
    // bypass can take effect without one.
    always_comb begin : p_bypass
        w_op1 = vrf_read_data1;
        w_op2 = vrf_read_data2;
        if (wb_write_en && (wb_write_addr == w_addr1)) begin
            w_op1 = wb_write_data;
        end
        if (wb_write_en && (wb_write_addr == w_addr2)) begin
            w_op2 = wb_write_data;
        end
    end

    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data1_q <= '0;
            rsp_data2_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= w_grant;
            if (w_grant) begin
                rsp_id_q    <= w_win_id;
                rsp_data1_q <= w_op1;
                rsp_data2_q <= w_op2;
            end
        end
    end

    assign req_ready      = w_ready;
    assign vrf_read_addr1 = w_addr1;
    assign vrf_read_addr2 = w_addr2;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_id         = rsp_id_q;
    assign rsp_data1      = rsp_data1_q;
    assign rsp_data2      = rsp_data2_q;

endmodule
`default_nettype wire

// File: doc/vrf_read_arbiter.md
Name: vrf_read_arbiter

Overview:
Shares the two combinational read ports of the vector register file among NUM_REQ requesters, such as the vector ALU issue, the vector LSU store-data path and the vector reduction unit.
- Grants one requester per cycle using round-robin and drives both VRF read addresses.
- Registers the read operands, forwarding any same-cycle commit write, and returns them one cycle later with the winner's ID.
- Sits between the vector issue/execute units and the VRF, alongside the commit write path.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
VLEN, 128, vector register width in bits
ADDR_W, 5, register address width (32 vector registers)
ID_W, $clog2(NUM_REQ), width of requester ID

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
arb_hold  input  1  when 1, no grants issued (e.g. during vtype/vl change)
req_valid  input  NUM_REQ  per-requester read request
req_ready  output  NUM_REQ  one-hot grant, valid in same cycle
req_src1  input  NUM_REQ*ADDR_W  packed operand-1 addresses, requester i at [i*ADDR_W +: ADDR_W]
req_src2  input  NUM_REQ*ADDR_W  packed operand-2 addresses, same packing
vrf_read_addr1  output  ADDR_W  to VRF read port 1
vrf_read_addr2  output  ADDR_W  to VRF read port 2
vrf_read_data1  input  VLEN  from VRF port 1 (combinational)
vrf_read_data2  input  VLEN  from VRF port 2 (combinational)
wb_write_en  input  1  snoop of commit write enable to the VRF
wb_write_addr  input  ADDR_W  snoop of commit write address
wb_write_data  input  VLEN  snoop of commit write data
rsp_valid  output  1  operand response valid, one-cycle pulse
rsp_id  output  ID_W  requester the response belongs to
rsp_data1  output  VLEN  operand 1
rsp_data2  output  VLEN  operand 2

Behaviour:
Arbitration:
- rr_ptr register, ID_W bits, resets to 0.
- Each cycle, if arb_hold=0, scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set bit is the winner.
- req_ready is one-hot at the winner. It is all-zero if there is no valid request or if arb_hold=1.
- req_ready depends combinationally on req_valid. A requester must not make req_valid depend on req_ready.
- A request is consumed when req_valid & req_ready. A requester keeps valid and its addresses stable until granted.
- On grant: rr_ptr <= (winner+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- With no grant, rr_ptr holds.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles while arb_hold=0.

Address drive:
- vrf_read_addr1/2 = winner's src1/src2, combinationally.
- With no grant, both addresses are 0.

Response path (latency 1):
- At the posedge after a grant cycle: rsp_valid<=1, rsp_id<=winner, rsp_data1/2 <= operand values sampled in the grant cycle.
- Otherwise rsp_valid<=0. rsp_id and rsp_data hold their last values.
- Consumers cannot back-pressure; the response must be taken in the cycle rsp_valid=1.

Write bypass:
- If wb_write_en=1 and wb_write_addr==vrf_read_addr1 in the grant cycle, rsp_data1 takes wb_write_data instead of vrf_read_data1.
- Port 2 is bypassed independently under the same rule.
- If src1==src2==wb_write_addr, both ports are bypassed.
- There is no bypass when there is no grant.

Reset (rst=1 at a posedge):
- rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_data1/2=0.
- Any grant made in the reset cycle is discarded; no response follows it.
- Outputs during reset: req_ready=0 and vrf_read_addr1/2=0, regardless of inputs.

Other rules:
- arb_hold=1 in a grant-eligible cycle blocks that grant. A response already registered from the previous cycle is still presented.

Test Plan:
- Reset, then req_valid=3'b111 held for 6 cycles, arb_hold=0 -> grants 0,1,2,0,1,2. rsp_valid is high from cycle 2 onward, with rsp_id trailing the grant by 1 cycle.
- Only requester 2 valid, src1=5, src2=9, VRF v5=A, v9=B -> vrf_read_addr1=5 and vrf_read_addr2=9 in the grant cycle. The next cycle gives rsp_id=2, data1=A, data2=B, and rr_ptr=0.
- Grant with src1=7, src2=3, plus a same-cycle wb_write_en=1, addr=7, data=0xDEAD... -> rsp_data1=0xDEAD..., rsp_data2=old v3. Repeat with src1=src2=7 -> both outputs are 0xDEAD....
- req_valid=3'b011 with arb_hold=1 for 3 cycles -> req_ready=0, no rsp_valid, rr_ptr unchanged. Release hold -> requester 0 is granted first.
- Grant requester 1, assert rst on the next cycle -> rsp_valid=0, rsp_id=0, rsp_data=0. The first grant after reset goes to requester 0 even if requester 1 is also valid.
- NUM_REQ=3, rr_ptr=2, req_valid=3'b001 -> requester 0 granted (wrap-around) and rr_ptr becomes 1.
